// File: rtl/grid_reader.sv
// Passive pixel-stream tap: samples one pixel per board cell, emits row masks.
// Optional GRID_READER_MATCH_EN: occupied means rgb_in == match_color.
module grid_reader #(
  parameter int          X0         = 201,
  parameter int          Y0         = 10,
  parameter int          CELL       = 35,
  parameter int          COLS       = 10,
  parameter int          ROWS       = 20,
  parameter int          SAMPLE_OFS = 17,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  localparam int         CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [10:0]   hcount_in,
  input  logic [10:0]   vcount_in,
  input  logic          hblnk_in,
  input  logic          vblnk_in,
  input  logic [11:0]   rgb_in,
`ifdef GRID_READER_MATCH_EN
  input  logic [11:0]   match_color,
`endif
  input  logic          row_ready,
  output logic [COLS-1:0] row_mask,
  output logic [RW-1:0] row_idx,
  output logic          row_valid,
  output logic          frame_done,
  output logic          overrun
);

  localparam logic [10:0] HS0  = 11'(X0 + SAMPLE_OFS);
  localparam logic [10:0] VS0  = 11'(Y0 + SAMPLE_OFS);
  localparam logic [10:0] STEP = 11'(CELL);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [COLS-1:0] r_acc;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [10:0]     r_hs;
  logic [10:0]     r_vs;
  logic            r_pend;

  logic w_fstart;
  logic w_hit;
  logic w_occ;
  logic w_load;
  logic w_last_row;
  logic w_last_col;

  assign w_fstart   = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign w_last_row = (r_row == RW'(ROWS - 1));
  assign w_last_col = (r_col == CW'(COLS - 1));

`ifdef GRID_READER_MATCH_EN
  assign w_occ = (rgb_in == match_color) && !hblnk_in && !vblnk_in;
`else
  assign w_occ = (rgb_in != BG_COLOR) && !hblnk_in && !vblnk_in;
`endif

  assign w_hit = (r_state == SCAN) && !w_fstart &&
                 (hcount_in == r_hs) && (vcount_in == r_vs);

  // The row completes one edge after its last sample lands in r_acc
  assign w_load = (r_state == SCAN) && r_pend && !w_fstart;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_fstart) w_next = SCAN;
      end
      SCAN: begin
        if (w_fstart)                 w_next = SCAN;
        else if (w_load && w_last_row) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_hs   <= HS0;
      r_vs   <= VS0;
      r_pend <= 1'b0;
    end else if (w_fstart && (r_state != DONE)) begin
      r_acc  <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_hs   <= HS0;
      r_vs   <= VS0;
      r_pend <= 1'b0;
    end else if (r_state == SCAN) begin
      if (w_hit) begin
        r_acc[r_col] <= w_occ;
        if (w_last_col) begin
          r_col  <= '0;
          r_hs   <= HS0;
          r_pend <= 1'b1;
        end else begin
          r_col <= r_col + CW'(1);
          r_hs  <= r_hs + STEP;
        end
      end
      if (w_load) begin
        r_acc  <= '0;
        r_pend <= 1'b0;
        r_vs   <= r_vs + STEP;
        if (!w_last_row) r_row <= r_row + RW'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      row_mask   <= '0;
      row_idx    <= '0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= w_load && w_last_row;
      if (w_load) begin
        row_mask  <= r_acc;
        row_idx   <= r_row;
        row_valid <= 1'b1;
        if (row_valid && !row_ready) overrun <= 1'b1;
      end else if (row_valid && row_ready) begin
        row_valid <= 1'b0;
      end
    end
  end

endmodule
